// File: rtl/vend_pay_ctrl_pkg.sv
// Shared constants and types for the vending payment controller.
// Holds the drink and control scan codes, the phase encoding seen by the
// display stage, datapath widths and the blank display digit code.
package vend_pay_ctrl_pkg;

   localparam int unsigned CODE_W  = 8;
   localparam int unsigned PAID_W  = 7;
   localparam int unsigned DIGIT_W = 5;
   localparam int unsigned PAID_MAX = 99;

   localparam logic [CODE_W-1:0] DRINK_C    = 8'h21;
   localparam logic [CODE_W-1:0] DRINK_S    = 8'h1B;
   localparam logic [CODE_W-1:0] DRINK_F    = 8'h2B;
   localparam logic [CODE_W-1:0] DRINK_P    = 8'h4D;
   localparam logic [CODE_W-1:0] DRINK_NONE = 8'h00;

   localparam logic [CODE_W-1:0] KEY_ENTER_CODE = 8'h5A;
   localparam logic [CODE_W-1:0] KEY_ESC_CODE   = 8'h76;

   // Digit code the display stage renders as an unlit position
   localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 5'd21;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SELECT = 2'b01,
      ST_PAY    = 2'b10,
      ST_DONE   = 2'b11
   } vend_state_e;

   // True for the four scan codes that select a drink
   function automatic logic is_drink(input logic [CODE_W-1:0] code);
      return (code == DRINK_C) || (code == DRINK_S) ||
             (code == DRINK_F) || (code == DRINK_P);
   endfunction

endpackage

// File: rtl/vend_pay_ctrl_bin_to_dec2.sv
// Combinational 7-bit binary to two decimal digits.
// Ports: bin (0..99 expected), tens/ones (0..9). Values above 99 cannot
// be shown in two digits and render both positions blank.
module bin_to_dec2
   import vend_pay_ctrl_pkg::*;
(
   input  logic [PAID_W-1:0]  bin,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] ones
);

   always_comb begin
      tens = BLANK_DIGIT;
      ones = BLANK_DIGIT;
      if (bin <= PAID_W'(PAID_MAX)) begin
         tens = DIGIT_W'(bin / PAID_W'(10));
         ones = DIGIT_W'(bin % PAID_W'(10));
      end
   end

endmodule

// File: rtl/vend_pay_ctrl.sv
// Vending transaction controller feeding the payment display stage.
// Ports:
//   clkSevenSeg, reset (async, active-low)
//   key_valid/key_code  : keyboard make-code strobe
//   coin1/coin5/coin10  : one-cycle coin pulses
//   State, drink, Paid_1, Paid_0 : display-stage inputs
//   Change_1, Change_0  : change digits, meaningful in DONE
//   dispense, coin_reject : one-cycle event pulses
module vend_pay_ctrl
   import vend_pay_ctrl_pkg::*;
#(
   parameter int unsigned        PRICE_C     = 15,
   parameter int unsigned        PRICE_S     = 20,
   parameter int unsigned        PRICE_F     = 25,
   parameter int unsigned        PRICE_P     = 30,
   parameter logic [CODE_W-1:0]  KEY_ENTER   = KEY_ENTER_CODE,
   parameter logic [CODE_W-1:0]  KEY_ESC     = KEY_ESC_CODE,
   parameter int unsigned        HOLD_CYCLES = 2000
) (
   input  logic                clkSevenSeg,
   input  logic                reset,
   input  logic                key_valid,
   input  logic [CODE_W-1:0]   key_code,
   input  logic                coin1,
   input  logic                coin5,
   input  logic                coin10,
   output logic [1:0]          State,
   output logic [CODE_W-1:0]   drink,
   output logic [DIGIT_W-1:0]  Paid_1,
   output logic [DIGIT_W-1:0]  Paid_0,
   output logic [DIGIT_W-1:0]  Change_1,
   output logic [DIGIT_W-1:0]  Change_0,
   output logic                dispense,
   output logic                coin_reject
);

   localparam int unsigned      HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   vend_state_e         state_q, state_d;
   logic [CODE_W-1:0]   drink_q, drink_d;
   logic [PAID_W-1:0]   paid_q, paid_d;
   logic [PAID_W-1:0]   change_q, change_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                dispense_d, coin_reject_d;
   logic [DIGIT_W-1:0]  paid_tens_d, paid_ones_d;
   logic [DIGIT_W-1:0]  change_tens_d, change_ones_d;

   logic                coin_any, coin_multi, coin_over;
   logic [PAID_W-1:0]   coin_val;
   logic [PAID_W:0]     coin_sum;
   logic [PAID_W-1:0]   paid_acc;
   logic [PAID_W-1:0]   price;

   // Coin arbitration: coin10 beats coin5 beats coin1
   always_comb begin
      coin_val = '0;
      if (coin10)     coin_val = PAID_W'(10);
      else if (coin5) coin_val = PAID_W'(5);
      else if (coin1) coin_val = PAID_W'(1);
   end

   assign coin_any   = coin1 | coin5 | coin10;
   assign coin_multi = (coin10 & (coin5 | coin1)) | (coin5 & coin1);
   assign coin_sum   = {1'b0, paid_q} + {1'b0, coin_val};
   assign coin_over  = coin_sum > (PAID_W + 1)'(PAID_MAX);

   // Price of the latched drink
   always_comb begin
      case (drink_q)
         DRINK_C: price = PAID_W'(PRICE_C);
         DRINK_S: price = PAID_W'(PRICE_S);
         DRINK_F: price = PAID_W'(PRICE_F);
         DRINK_P: price = PAID_W'(PRICE_P);
         default: price = PAID_W'(PAID_MAX);
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      drink_d       = drink_q;
      paid_d        = paid_q;
      change_d      = change_q;
      hold_d        = hold_q;
      dispense_d    = 1'b0;
      coin_reject_d = 1'b0;
      paid_acc      = paid_q;

      case (state_q)
         ST_IDLE: begin
            coin_reject_d = coin_any;
            if (key_valid && is_drink(key_code)) begin
               drink_d = key_code;
               state_d = ST_SELECT;
            end
         end

         ST_SELECT: begin
            coin_reject_d = coin_any;
            if (key_valid) begin
               if (is_drink(key_code)) begin
                  drink_d = key_code;
               end else if (key_code == KEY_ENTER) begin
                  state_d = ST_PAY;
                  paid_d  = '0;
               end else if (key_code == KEY_ESC) begin
                  state_d = ST_IDLE;
                  drink_d = DRINK_NONE;
               end
            end
         end

         ST_PAY: begin
            // Losing coins and a coin that would pass 99 are refused
            coin_reject_d = coin_multi | (coin_any & coin_over);
            if (coin_any && !coin_over) paid_acc = coin_sum[PAID_W-1:0];
            paid_d = paid_acc;
            // The coin is counted before ESC, so a completing coin wins
            if (paid_acc >= price) begin
               state_d    = ST_DONE;
               dispense_d = 1'b1;
               change_d   = paid_acc - price;
               hold_d     = '0;
            end else if (key_valid && (key_code == KEY_ESC)) begin
               state_d  = ST_DONE;
               change_d = paid_acc;
               hold_d   = '0;
            end
         end

         ST_DONE: begin
            coin_reject_d = coin_any;
            if (hold_q == HOLD_LAST) begin
               state_d  = ST_IDLE;
               drink_d  = DRINK_NONE;
               paid_d   = '0;
               change_d = '0;
               hold_d   = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Digits are derived from next values so the display outputs are registered
   bin_to_dec2 u_paid_dec (
      .bin  (paid_d),
      .tens (paid_tens_d),
      .ones (paid_ones_d)
   );

   bin_to_dec2 u_change_dec (
      .bin  (change_d),
      .tens (change_tens_d),
      .ones (change_ones_d)
   );

   // State and output registers
   always_ff @(posedge clkSevenSeg or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         drink_q     <= DRINK_NONE;
         paid_q      <= '0;
         change_q    <= '0;
         hold_q      <= '0;
         Paid_1      <= '0;
         Paid_0      <= '0;
         Change_1    <= '0;
         Change_0    <= '0;
         dispense    <= 1'b0;
         coin_reject <= 1'b0;
      end else begin
         state_q     <= state_d;
         drink_q     <= drink_d;
         paid_q      <= paid_d;
         change_q    <= change_d;
         hold_q      <= hold_d;
         Paid_1      <= paid_tens_d;
         Paid_0      <= paid_ones_d;
         Change_1    <= change_tens_d;
         Change_0    <= change_ones_d;
         dispense    <= dispense_d;
         coin_reject <= coin_reject_d;
      end
   end

   assign State = state_q;
   assign drink = drink_q;

endmodule

// File: tb/tb_vend_pay_ctrl.sv
// Self-checking bench for vend_pay_ctrl: a directed vector table, directed
// corner sequences and random traffic against a transaction-level model.
module tb_vend_pay_ctrl;

   localparam int P_C  = 15;
   localparam int P_S  = 20;
   localparam int P_F  = 99;
   localparam int P_P  = 30;
   localparam int HOLD = 8;

   logic       clkSevenSeg = 1'b0;
   logic       reset       = 1'b0;
   logic       key_valid   = 1'b0;
   logic [7:0] key_code    = 8'h00;
   logic       coin1 = 1'b0, coin5 = 1'b0, coin10 = 1'b0;
   logic [1:0] State;
   logic [7:0] drink;
   logic [4:0] Paid_1, Paid_0, Change_1, Change_0;
   logic       dispense, coin_reject;

   int checks = 0;
   int errors = 0;

   vend_pay_ctrl #(
      .PRICE_C(P_C), .PRICE_S(P_S), .PRICE_F(P_F), .PRICE_P(P_P),
      .KEY_ENTER(8'h5A), .KEY_ESC(8'h76), .HOLD_CYCLES(HOLD)
   ) dut (
      .clkSevenSeg (clkSevenSeg),
      .reset       (reset),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .coin1       (coin1),
      .coin5       (coin5),
      .coin10      (coin10),
      .State       (State),
      .drink       (drink),
      .Paid_1      (Paid_1),
      .Paid_0      (Paid_0),
      .Change_1    (Change_1),
      .Change_0    (Change_0),
      .dispense    (dispense),
      .coin_reject (coin_reject)
   );

   always #5 clkSevenSeg = ~clkSevenSeg;

   // ---------------- reference model (transaction level) ----------------
   int m_phase;   // 0 idle, 1 select, 2 pay, 3 done
   int m_drink, m_paid, m_change, m_hold, m_disp, m_rej;

   function automatic int price_of(input int d);
      case (d)
         'h21: return P_C;
         'h1B: return P_S;
         'h2B: return P_F;
         'h4D: return P_P;
         default: return 1000;
      endcase
   endfunction

   function automatic bit drink_code(input int d);
      return d == 'h21 || d == 'h1B || d == 'h2B || d == 'h4D;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_drink = 0; m_paid = 0; m_change = 0;
      m_hold = 0; m_disp = 0; m_rej = 0;
   endtask

   task automatic model_update(input bit kv, input int code,
                               input bit c1, input bit c5, input bit c10);
      int ncoins, val;
      ncoins = int'(c1) + int'(c5) + int'(c10);
      m_disp = 0;
      m_rej  = 0;
      if (m_phase == 0) begin
         if (ncoins > 0) m_rej = 1;
         if (kv && drink_code(code)) begin m_drink = code; m_phase = 1; end
      end else if (m_phase == 1) begin
         if (ncoins > 0) m_rej = 1;
         if (kv && drink_code(code)) m_drink = code;
         else if (kv && code == 'h5A) begin m_phase = 2; m_paid = 0; end
         else if (kv && code == 'h76) begin m_phase = 0; m_drink = 0; end
      end else if (m_phase == 2) begin
         val = c10 ? 10 : (c5 ? 5 : (c1 ? 1 : 0));
         if (ncoins > 1) m_rej = 1;
         if (m_paid + val > 99) begin m_rej = 1; val = 0; end
         m_paid += val;
         if (m_paid >= price_of(m_drink)) begin
            m_phase = 3; m_disp = 1; m_change = m_paid - price_of(m_drink); m_hold = 0;
         end else if (kv && code == 'h76) begin
            m_phase = 3; m_change = m_paid; m_hold = 0;
         end
      end else begin
         if (ncoins > 0) m_rej = 1;
         m_hold++;
         if (m_hold == HOLD) begin
            m_phase = 0; m_drink = 0; m_paid = 0; m_change = 0; m_hold = 0;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic chk_model();
      chk("State",       int'(State),       m_phase);
      chk("drink",       int'(drink),       m_drink);
      chk("Paid_1",      int'(Paid_1),      m_paid / 10);
      chk("Paid_0",      int'(Paid_0),      m_paid % 10);
      chk("Change_1",    int'(Change_1),    m_change / 10);
      chk("Change_0",    int'(Change_0),    m_change % 10);
      chk("dispense",    int'(dispense),    m_disp);
      chk("coin_reject", int'(coin_reject), m_rej);
   endtask

   // Apply one cycle of stimulus, then compare against the model
   task automatic step(input bit kv, input logic [7:0] code,
                       input bit c1, input bit c5, input bit c10);
      key_valid = kv; key_code = code; coin1 = c1; coin5 = c5; coin10 = c10;
      @(posedge clkSevenSeg);
      #1;
      key_valid = 1'b0; coin1 = 1'b0; coin5 = 1'b0; coin10 = 1'b0;
      model_update(kv, int'(code), c1, c5, c10);
      chk_model();
   endtask

   task automatic key(input logic [7:0] code);
      step(1'b1, code, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4 * HOLD && State != 2'b00; i++) idle();
      chk("wait_idle", int'(State), 0);
   endtask

   // Asynchronous reset: outputs must clear without a clock edge
   task automatic do_reset();
      reset = 1'b0;
      #2;
      chk("rst_State",  int'(State),  0);
      chk("rst_drink",  int'(drink),  0);
      chk("rst_Paid_1", int'(Paid_1), 0);
      chk("rst_Paid_0", int'(Paid_0), 0);
      chk("rst_Change", int'({Change_1, Change_0}), 0);
      chk("rst_pulses", int'({dispense, coin_reject}), 0);
      model_reset();
      @(posedge clkSevenSeg);
      #1;
      reset = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit kv; logic [7:0] code; bit c1, c5, c10;
      int st, dr, p1, p0, ch1, ch0, disp, rej;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [7:0] rc;
      model_reset();
      #12;
      do_reset();

      //          kv  code  c1 c5 c10  st  dr     p1 p0 ch1 ch0 dsp rej
      vecs[0]  = '{0, 8'h00, 1, 0, 0,  0, 'h00,  0, 0, 0, 0, 0, 1};
      vecs[1]  = '{1, 8'h5A, 0, 0, 0,  0, 'h00,  0, 0, 0, 0, 0, 0};
      vecs[2]  = '{1, 8'h21, 0, 0, 0,  1, 'h21,  0, 0, 0, 0, 0, 0};
      vecs[3]  = '{1, 8'h1B, 0, 0, 0,  1, 'h1B,  0, 0, 0, 0, 0, 0};
      vecs[4]  = '{0, 8'h00, 0, 1, 0,  1, 'h1B,  0, 0, 0, 0, 0, 1};
      vecs[5]  = '{1, 8'h76, 0, 0, 0,  0, 'h00,  0, 0, 0, 0, 0, 0};
      vecs[6]  = '{1, 8'h21, 0, 0, 0,  1, 'h21,  0, 0, 0, 0, 0, 0};
      vecs[7]  = '{1, 8'h5A, 0, 0, 0,  2, 'h21,  0, 0, 0, 0, 0, 0};
      vecs[8]  = '{0, 8'h00, 0, 0, 1,  2, 'h21,  1, 0, 0, 0, 0, 0};
      vecs[9]  = '{0, 8'h00, 0, 1, 0,  3, 'h21,  1, 5, 0, 0, 1, 0};
      vecs[10] = '{0, 8'h00, 0, 0, 0,  3, 'h21,  1, 5, 0, 0, 0, 0};
      vecs[11] = '{0, 8'h00, 0, 0, 1,  3, 'h21,  1, 5, 0, 0, 0, 1};

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].kv, vecs[i].code, vecs[i].c1, vecs[i].c5, vecs[i].c10);
         chk($sformatf("vec%0d_State", i),  int'(State),       vecs[i].st);
         chk($sformatf("vec%0d_drink", i),  int'(drink),       vecs[i].dr);
         chk($sformatf("vec%0d_Paid", i),   int'(Paid_1) * 10 + int'(Paid_0), vecs[i].p1 * 10 + vecs[i].p0);
         chk($sformatf("vec%0d_Change", i), int'(Change_1) * 10 + int'(Change_0), vecs[i].ch1 * 10 + vecs[i].ch0);
         chk($sformatf("vec%0d_disp", i),   int'(dispense),    vecs[i].disp);
         chk($sformatf("vec%0d_rej", i),    int'(coin_reject), vecs[i].rej);
      end
      wait_idle();

      // Drink P: third coin10 completes; coin5 in DONE is refused
      key(8'h4D); key(8'h5A);
      step(0, 8'h00, 0, 0, 1); step(0, 8'h00, 0, 0, 1); step(0, 8'h00, 0, 0, 1);
      chk("P_done_State", int'(State), 3);
      chk("P_dispense",   int'(dispense), 1);
      chk("P_paid",       int'(Paid_1) * 10 + int'(Paid_0), 30);
      chk("P_change",     int'(Change_1) * 10 + int'(Change_0), 0);
      step(0, 8'h00, 0, 1, 0);
      chk("P_late_rej",   int'(coin_reject), 1);
      chk("P_late_paid",  int'(Paid_1) * 10 + int'(Paid_0), 30);
      wait_idle();

      // Drink F: refund via ESC, then DONE lasts exactly HOLD cycles
      key(8'h2B); key(8'h5A); step(0, 8'h00, 0, 0, 1); key(8'h76);
      chk("F_esc_State", int'(State), 3);
      chk("F_esc_disp",  int'(dispense), 0);
      chk("F_change",    int'(Change_1) * 10 + int'(Change_0), 10);
      begin
         int done_cycles = 1;
         for (int i = 0; i < 4 * HOLD && State == 2'b11; i++) begin
            idle();
            if (State == 2'b11) done_cycles++;
         end
         chk("F_done_len", done_cycles, HOLD);
         chk("F_back_idle", int'(State), 0);
      end

      // Drink F priced 99: overflow refusal at 95, then four coin1 complete
      key(8'h2B); key(8'h5A);
      for (int i = 0; i < 9; i++) step(0, 8'h00, 0, 0, 1);
      step(0, 8'h00, 0, 1, 0);
      step(0, 8'h00, 0, 0, 1);
      chk("OV_rej",  int'(coin_reject), 1);
      chk("OV_paid", int'(Paid_1) * 10 + int'(Paid_0), 95);
      chk("OV_State", int'(State), 2);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
      chk("OV_done",  int'(State), 3);
      chk("OV_disp",  int'(dispense), 1);
      wait_idle();

      // Drink S: simultaneous coin10+coin1 with paid=5
      key(8'h1B); key(8'h5A); step(0, 8'h00, 0, 1, 0);
      step(0, 8'h00, 1, 0, 1);
      chk("SIM_paid", int'(Paid_1) * 10 + int'(Paid_0), 15);
      chk("SIM_rej",  int'(coin_reject), 1);
      chk("SIM_State", int'(State), 2);
      key(8'h76);
      chk("SIM_refund", int'(Change_1) * 10 + int'(Change_0), 15);
      wait_idle();

      // Reset asserted mid-PAY with paid=17
      key(8'h4D); key(8'h5A);
      step(0, 8'h00, 0, 0, 1); step(0, 8'h00, 0, 1, 0);
      step(0, 8'h00, 1, 0, 0); step(0, 8'h00, 1, 0, 0);
      chk("MID_paid", int'(Paid_1) * 10 + int'(Paid_0), 17);
      do_reset();

      // Random traffic against the model
      for (int n = 0; n < 2000; n++) begin
         case ($urandom_range(0, 7))
            0: rc = 8'h21;
            1: rc = 8'h1B;
            2: rc = 8'h2B;
            3: rc = 8'h4D;
            4, 5: rc = 8'h5A;
            6: rc = 8'h76;
            default: rc = 8'($urandom);
         endcase
         step($urandom_range(0, 3) == 0, rc,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vend_pay_ctrl.md
# vend_pay_ctrl

Vending-machine transaction controller sitting directly upstream of the payment display stage. It decodes keyboard scan codes into a drink selection, accumulates coin insertions as a two-digit decimal amount, and walks the machine through idle/select/pay/dispense phases. Its `State`, `drink`, `Paid_1` and `Paid_0` outputs are the exact inputs the display stage consumes, all in the same `clkSevenSeg` domain.

## Interface
Parameters:
- `PRICE_C`, 15: price of drink C (scan code 8'h21), decimal, 1..99
- `PRICE_S`, 20: price of drink S (8'h1B)
- `PRICE_F`, 25: price of drink F (8'h2B)
- `PRICE_P`, 30: price of drink P (8'h4D)
- `KEY_ENTER`, 8'h5A: confirm scan code
- `KEY_ESC`, 8'h76: cancel scan code
- `HOLD_CYCLES`, 2000: `clkSevenSeg` cycles spent in DONE

Ports:
- `clkSevenSeg`  in  1  block clock (slow display clock)
- `reset`  in  1  asynchronous, active-low
- `key_valid`  in  1  one-cycle strobe; `key_code` valid
- `key_code`  in  8  PS/2 make code
- `coin1`, `coin5`, `coin10`  in  1 each  one-cycle coin pulses (pre-debounced)
- `State`  out  2  00 IDLE, 01 SELECT, 10 PAY, 11 DONE
- `drink`  out  8  latched drink scan code, 8'h00 when none
- `Paid_1`  out  5  tens digit of paid amount, 0..9
- `Paid_0`  out  5  ones digit of paid amount, 0..9
- `Change_1`, `Change_0`  out  5 each  change digits, valid in DONE
- `dispense`  out  1  one-cycle pulse on PAY→DONE when purchase completes
- `coin_reject`  out  1  one-cycle pulse when a coin is refused

## Operation
- Reset: `State`=00, `drink`=8'h00, `Paid_*`=0, `Change_*`=0, `dispense`=0, `coin_reject`=0, hold counter=0.
- IDLE: `key_valid` with a drink code (21/1B/2B/4D) → latch `drink`, go SELECT. Other codes ignored. Coins in IDLE → `coin_reject`.
- SELECT: drink code → overwrite `drink`, stay. `KEY_ENTER` → PAY, paid cleared to 0. `KEY_ESC` → IDLE, `drink`=00. Coins → `coin_reject`.
- PAY: each coin adds 1/5/10. Internal paid held as 7-bit binary; digits are paid/10 and paid%10. If paid+coin > 99 the coin is refused (`coin_reject`, paid unchanged). When paid ≥ price of latched drink → DONE, `dispense`=1 for that cycle, change = paid − price. `KEY_ESC` → DONE with change = paid, no `dispense` (refund).
- Simultaneous coins in one cycle: priority coin10 > coin5 > coin1; only the winner is counted, others flagged `coin_reject`.
- Coin and `KEY_ESC` in the same PAY cycle: coin counted first, then the price check; if price is met, the purchase completes (ESC ignored); otherwise refund includes the coin.
- DONE: hold counter counts to `HOLD_CYCLES`−1, then → IDLE, clearing `drink`, paid, change. Keys and coins ignored (coins → `coin_reject`).
- Reset mid-transaction: immediate return to reset values; no dispense and no refund signalled.

## Timing
- All outputs registered; every state or value change is visible one `clkSevenSeg` edge after the triggering strobe.
- Price check uses the updated sum in the same cycle: the coin that reaches the price produces `State`=11 and `dispense`=1 on the same edge.
- `dispense` and `coin_reject` are high for exactly one cycle.
- DONE lasts exactly `HOLD_CYCLES` cycles.

## Structure
- Shared package: drink scan-code constants (C/S/F/P), `KEY_ENTER`/`KEY_ESC`, the state encodings, and the blank display code 21.
- Sub-module `bin_to_dec2`: combinational 7-bit binary (0..99) → two 5-bit digits. Instantiated twice, once for paid and once for change.
- Price lookup is a combinational case on `drink`.

## Test plan
- Reset asserted mid-PAY with paid=17 → `State`=00, `drink`=00, `Paid_1`=0, `Paid_0`=0 immediately (asynchronous).
- Key 21, Enter, coins 10, 5 → `Paid` 1/0 then 1/5; `State`=11 and `dispense` pulse on the coin5 edge; change 0/0.
- Key 4D, Enter, coins 10, 10, 10, 5 → DONE on the third 10 with `Paid`=3/0 and change 0/0; the coin5 arriving in DONE → `coin_reject`, paid unchanged.
- Key 2B, Enter, coin10, Esc → DONE with no `dispense`, change 1/0; returns to IDLE after `HOLD_CYCLES`.
- Overflow check: price set to 99, paid=95, coin10 → `coin_reject`, paid stays 9/5; then coin1 ×4 → DONE.
- Simultaneous coin10+coin1 with `drink` S and paid=5 → paid becomes 15, `coin_reject`=1; then key 1B in SELECT re-latch (separate run) → `drink` updated.
